// File: rtl/ext_pkg.sv
// Shared CPU datapath control encodings used by the decode and execute stages.
// Extension-mode select codes live here alongside ALU and writeback selects.
package ext_pkg;

  localparam int XLEN = 32;
  localparam int IMM_W = 16;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_BR   = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ext.sv
// Immediate extender: combinational imm32 (0 cycles) plus registered imm32_q (1 cycle).
// No backpressure, every in_valid is captured. EXT_BRANCH_SHIFT_EN enables ExtOp=11 branch offsets.
module ext
  import ext_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imm16,
  input  logic [1:0]  ExtOp,
  input  logic        in_valid,
  output logic [31:0] imm32,
  output logic [31:0] imm32_q,
  output logic        out_valid
);

  // An unknown ExtOp falls to the default arm so X reaches the outputs.
  always_comb begin
    imm32 = 'x;
    case (ExtOp)
      EXT_ZERO: imm32 = {16'h0000, imm16};
      EXT_SIGN: imm32 = sext16(imm16);
      EXT_LUI:  imm32 = {imm16, 16'h0000};
      EXT_BR: begin
`ifdef EXT_BRANCH_SHIFT_EN
        imm32 = {{14{imm16[15]}}, imm16, 2'b00};
`else
        imm32 = 32'h0000_0000;
`endif
      end
      default:  imm32 = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm32_q   <= RESET_VAL;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) imm32_q <= imm32;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_ext.sv
// Randomized self-checking bench for ext with a spec-level reference model.
module tb_ext;

  localparam logic [31:0] RV = 32'hA5A5_0F0F;

  logic        clk;
  logic        reset;
  logic [15:0] imm16;
  logic [1:0]  ExtOp;
  logic        in_valid;
  logic [31:0] imm32;
  logic [31:0] imm32_q;
  logic        out_valid;

  int tests = 0;
  int fails = 0;
  bit compare_en = 0;
  logic [31:0] exp_q;
  logic        exp_v;

  ext #(.RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .imm16(imm16), .ExtOp(ExtOp), .in_valid(in_valid),
    .imm32(imm32), .imm32_q(imm32_q), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] op);
    int s;
    s = int'($signed(i));
    case (op)
      2'd0: return 32'(int'(i));
      2'd1: return 32'(s);
      2'd2: return 32'(int'(i) * 65536);
`ifdef EXT_BRANCH_SHIFT_EN
      default: return 32'(s * 4);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      check("imm32", imm32, model(imm16, ExtOp));
      check("imm32_q", imm32_q, exp_q);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    end
  end

  initial begin
    reset = 1'b1; imm16 = 16'h0000; ExtOp = 2'b00; in_valid = 1'b0;
    #3;
    check("rst_q", imm32_q, RV);
    check("rst_v", {31'd0, out_valid}, 32'd0);

    // Combinational literal checks, taken while reset is held.
    imm16 = 16'h8001; ExtOp = 2'b10; #1 check("lui_8001", imm32, 32'h8001_0000);
    ExtOp = 2'b00; #1 check("zext_8001", imm32, 32'h0000_8001);
    ExtOp = 2'b01; #1 check("sext_8001", imm32, 32'hFFFF_8001);
    imm16 = 16'h7FFF; #1 check("sext_7fff", imm32, 32'h0000_7FFF);
    imm16 = 16'h8001; ExtOp = 2'b11; #1;
`ifdef EXT_BRANCH_SHIFT_EN
    check("br_8001", imm32, 32'hFFFE_0004);
`else
    check("br_8001", imm32, 32'h0000_0000);
`endif

    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    check("post_rst_q", imm32_q, RV);
    in_valid = 1'b1; imm16 = 16'h1234; ExtOp = 2'b00;
    @(posedge clk); #1;
    check("cap_q", imm32_q, 32'h0000_1234);
    check("cap_v", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; imm16 = 16'hFFFF; ExtOp = 2'b01;
    @(posedge clk); #1;
    check("hold_q", imm32_q, 32'h0000_1234);
    check("hold_v", {31'd0, out_valid}, 32'd0);

    in_valid = 1'b1; imm16 = 16'h4321; ExtOp = 2'b10;
    @(posedge clk); #2;
    check("cap2_v", {31'd0, out_valid}, 32'd1);
    reset = 1'b1; #1;
    check("midrst_q", imm32_q, RV);
    check("midrst_v", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;

    exp_q = RV; exp_v = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    compare_en = 1;
    for (int n = 0; n < 2000; n++) begin
      imm16 = 16'($urandom);
      ExtOp = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1; #1;
        exp_q = RV; exp_v = 1'b0;
        check("rnd_rst_q", imm32_q, exp_q);
        check("rnd_rst_v", {31'd0, out_valid}, 32'd0);
        check("rnd_rst_imm32", imm32, model(imm16, ExtOp));
        #1 reset = 1'b0;
      end
      @(posedge clk);
      if (in_valid) exp_q = model(imm16, ExtOp);
      exp_v = in_valid;
      @(negedge clk); #1;
    end
    compare_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext.md
EXT -- requirements
Module: ext

Interface
REQ-001 Parameter: RESET_VAL, default 32'h0000_0000, value loaded into imm32_q on reset.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imm16  input  16  raw instruction immediate field.
REQ-005 ExtOp  input  2  extension mode select.
REQ-006 in_valid  input  1  qualifies imm16/ExtOp for capture into the output register.
REQ-007 imm32  output  32  combinational extended immediate.
REQ-008 imm32_q  output  32  registered copy of imm32.
REQ-009 out_valid  output  1  imm32_q holds a value captured in the previous cycle.

Function
REQ-010 ExtOp=2'b00 (zero-extend) SHALL give imm32 = {16'h0000, imm16}.
REQ-011 ExtOp=2'b01 (sign-extend) SHALL give imm32 = {16{imm16[15]}, imm16}.
REQ-012 ExtOp=2'b10 (load-upper) SHALL give imm32 = {imm16, 16'h0000}.
REQ-013 ExtOp=2'b11 (branch offset) behaviour SHALL be set by the macro in the Configuration section.
REQ-014 imm32 SHALL be purely combinational: zero cycles of latency and no dependence on clk or reset.
REQ-015 On a rising clk edge with in_valid=1, imm32_q SHALL load imm32 and out_valid SHALL go to 1.
REQ-016 On a rising clk edge with in_valid=0, imm32_q SHALL hold its value and out_valid SHALL go to 0.
REQ-017 imm32_q SHALL lag imm32 by exactly one cycle.
REQ-018 The block SHALL have no handshake backpressure; every valid input is accepted.
REQ-019 X or Z on ExtOp SHALL NOT be masked; simulation propagates it to the outputs.

Reset
REQ-020 While reset=1, imm32_q SHALL be RESET_VAL and out_valid SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard any pending capture immediately.
REQ-022 The first capture after reset deassertion SHALL occur on the first rising edge with in_valid=1.
REQ-023 imm32 SHALL remain a function of the inputs during reset.

Configuration
REQ-024 Macro EXT_BRANCH_SHIFT_EN defined: ExtOp=2'b11 SHALL give imm32 = {14{imm16[15]}, imm16, 2'b00} (sign-extend, shift left 2).
REQ-025 Macro EXT_BRANCH_SHIFT_EN undefined: ExtOp=2'b11 SHALL give imm32 = 32'h0000_0000.

Structure
REQ-026 ExtOp encodings (EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BR) SHALL be constants in the shared CPU package, alongside the other datapath control encodings.
REQ-027 The block SHALL be a single module with no sub-modules: combinational mux plus one output register stage.

Verification
REQ-028 imm16=16'h8001, ExtOp=2'b10 -> imm32=32'h8001_0000.
REQ-029 imm16=16'h8001, ExtOp=2'b00 -> imm32=32'h0000_8001; ExtOp=2'b01 -> imm32=32'hFFFF_8001.
REQ-030 imm16=16'h7FFF, ExtOp=2'b01 -> imm32=32'h0000_7FFF (positive sign boundary).
REQ-031 imm16=16'h8001, ExtOp=2'b11 -> imm32=32'hFFFE_0004 with EXT_BRANCH_SHIFT_EN defined, 32'h0000_0000 without it.
REQ-032 in_valid=1, imm16=16'h1234, ExtOp=2'b00 for one edge -> next cycle imm32_q=32'h0000_1234 and out_valid=1; following edge with in_valid=0 -> out_valid=0 and imm32_q unchanged.
REQ-033 reset pulsed between clock edges after a capture -> imm32_q=RESET_VAL and out_valid=0 immediately, without waiting for a clock edge.
